// File: rtl/wb_regfile.sv
// Dual-lane writeback register file: per-lane result muxing, x1..x31 storage,
// four bypassing read ports and a wrapping count of committed writes.
module wb_regfile #(
  parameter int NREG = 32,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteW_0,
  input  logic [1:0]      ResultSrcW_0,
  input  logic [31:0]     AluResultW_0,
  input  logic [4:0]      RdW_0,
  input  logic [31:0]     PCPlus4W_0,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [31:0]     AluResultW,
  input  logic [31:0]     ReadDataW,
  input  logic [4:0]      RdW,
  input  logic [31:0]     PCPlus4W,
  input  logic [4:0]      Rs1D_0,
  input  logic [4:0]      Rs2D_0,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  output logic [31:0]     RD1D_0,
  output logic [31:0]     RD2D_0,
  output logic [31:0]     RD1D,
  output logic [31:0]     RD2D,
  output logic [31:0]     ResultW_0,
  output logic [31:0]     ResultW,
  output logic [CNTW-1:0] WrCount
);

  // x0 has no storage; address 0 is decoded to zero on every read port.
  logic [31:0]     regs_q [1:NREG-1];
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            commit0, commit1;
  logic [4:0]      rd_addr [4];

  always_comb begin
    case (ResultSrcW)
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = AluResultW;
    endcase
  end

  assign ResultW_0 = (ResultSrcW_0 == 2'b10) ? PCPlus4W_0 : AluResultW_0;

  assign commit0 = RegWriteW_0 && (RdW_0 != 5'd0) && rst;
  assign commit1 = RegWriteW   && (RdW   != 5'd0) && rst;

  // Lane 1 is younger: its write is issued last so it wins on a shared Rd.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (commit0) regs_q[RdW_0] <= ResultW_0;
      if (commit1) regs_q[RdW]   <= ResultW;
    end
  end

  assign rd_addr[0] = Rs1D_0;
  assign rd_addr[1] = Rs2D_0;
  assign rd_addr[2] = Rs1D;
  assign rd_addr[3] = Rs2D;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      logic [31:0] data;
      always_comb begin
        if (rd_addr[gi] == 5'd0)                  data = 32'h0;
        else if (commit1 && rd_addr[gi] == RdW)   data = ResultW;
        else if (commit0 && rd_addr[gi] == RdW_0) data = ResultW_0;
        else                                      data = regs_q[rd_addr[gi]];
      end
    end
  endgenerate

  assign RD1D_0 = g_rd[0].data;
  assign RD2D_0 = g_rd[1].data;
  assign RD1D   = g_rd[2].data;
  assign RD2D   = g_rd[3].data;

  assign cnt_d = cnt_q + CNTW'(commit0) + CNTW'(commit1);

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign WrCount = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table with hand-derived results,
// plus a reference model feeding a scoreboard queue for every output.
module tb_wb_regfile;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            RegWriteW_0, RegWriteW;
  logic [1:0]      ResultSrcW_0, ResultSrcW;
  logic [31:0]     AluResultW_0, PCPlus4W_0, AluResultW, ReadDataW, PCPlus4W;
  logic [4:0]      RdW_0, RdW, Rs1D_0, Rs2D_0, Rs1D, Rs2D;
  logic [31:0]     RD1D_0, RD2D_0, RD1D, RD2D, ResultW_0, ResultW;
  logic [CNTW-1:0] WrCount;

  wb_regfile #(.NREG(32), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW_0(RegWriteW_0), .ResultSrcW_0(ResultSrcW_0), .AluResultW_0(AluResultW_0),
    .RdW_0(RdW_0), .PCPlus4W_0(PCPlus4W_0),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .AluResultW(AluResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .Rs1D_0(Rs1D_0), .Rs2D_0(Rs2D_0), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1D_0(RD1D_0), .RD2D_0(RD2D_0), .RD1D(RD1D), .RD2D(RD2D),
    .ResultW_0(ResultW_0), .ResultW(ResultW), .WrCount(WrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw0; logic [1:0] src0; logic [31:0] alu0; logic [4:0] rd0; logic [31:0] pc0;
    logic        rw1; logic [1:0] src1; logic [31:0] alu1; logic [31:0] rdat1; logic [4:0] rd1;
    logic [31:0] pc1; logic [4:0] rs1;
    logic [31:0] e_res0; logic [31:0] e_res1; logic [31:0] e_rd1d; logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  vec_t            tbl [12];
  sb_t             sb_q [$];
  logic [31:0]     m_regs [32];
  logic [CNTW-1:0] m_cnt;
  int              n_pass = 0;
  int              n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] m_res0();
    return (ResultSrcW_0 == 2'b10) ? PCPlus4W_0 : AluResultW_0;
  endfunction

  function automatic logic [31:0] m_res1();
    if (ResultSrcW == 2'b01) return ReadDataW;
    if (ResultSrcW == 2'b10) return PCPlus4W;
    return AluResultW;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rst && RegWriteW && RdW != 5'd0 && a == RdW) return m_res1();
    if (rst && RegWriteW_0 && RdW_0 != 5'd0 && a == RdW_0) return m_res0();
    return m_regs[a];
  endfunction

  task automatic drive(input vec_t v, input logic rstn);
    rst = rstn;
    RegWriteW_0 = v.rw0; ResultSrcW_0 = v.src0; AluResultW_0 = v.alu0; RdW_0 = v.rd0; PCPlus4W_0 = v.pc0;
    RegWriteW = v.rw1; ResultSrcW = v.src1; AluResultW = v.alu1; ReadDataW = v.rdat1; RdW = v.rd1;
    PCPlus4W = v.pc1;
    Rs1D = v.rs1; Rs2D = v.rs1 ^ 5'd1; Rs1D_0 = 5'd7; Rs2D_0 = 5'd5;
  endtask

  // Expected values are queued from the model, then popped against the DUT outputs.
  task automatic sample_model(input string tag);
    sb_t e;
    sb_q.push_back('{{tag, ".ResultW_0"}, m_res0()});
    sb_q.push_back('{{tag, ".ResultW"},   m_res1()});
    sb_q.push_back('{{tag, ".RD1D_0"},    m_read(Rs1D_0)});
    sb_q.push_back('{{tag, ".RD2D_0"},    m_read(Rs2D_0)});
    sb_q.push_back('{{tag, ".RD1D"},      m_read(Rs1D)});
    sb_q.push_back('{{tag, ".RD2D"},      m_read(Rs2D)});
    e = sb_q.pop_front(); check(e.name, ResultW_0, e.exp);
    e = sb_q.pop_front(); check(e.name, ResultW,   e.exp);
    e = sb_q.pop_front(); check(e.name, RD1D_0,    e.exp);
    e = sb_q.pop_front(); check(e.name, RD2D_0,    e.exp);
    e = sb_q.pop_front(); check(e.name, RD1D,      e.exp);
    e = sb_q.pop_front(); check(e.name, RD2D,      e.exp);
  endtask

  // Advance the model with the inputs present at the coming edge, then clock the DUT.
  task automatic commit_edge(input string tag);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = '0;
    end else begin
      if (RegWriteW_0 && RdW_0 != 5'd0) begin m_regs[RdW_0] = m_res0(); m_cnt = m_cnt + 1'b1; end
      if (RegWriteW && RdW != 5'd0)     begin m_regs[RdW]   = m_res1(); m_cnt = m_cnt + 1'b1; end
    end
    @(posedge clk);
    #1;
    check({tag, ".WrCount"}, 32'(WrCount), 32'(m_cnt));
  endtask

  task automatic step(input string tag, input vec_t v, input logic rstn);
    drive(v, rstn);
    #1;
    sample_model(tag);
    commit_edge(tag);
  endtask

  initial begin
    vec_t idle;
    vec_t w;
    idle = '{1'b0, 2'd0, 32'h0, 5'd0, 32'h0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0,
             32'h0, 32'h0, 32'h0, 32'h0};
    //         rw0 src0 alu0 rd0 pc0 | rw1 src1 alu1 rdat1 rd1 pc1 | rs1 | res0 res1 rd1d cnt
    tbl[0]  = '{0, 2'd0, 32'h55,   5'd0,  32'h0,   1, 2'd1, 32'h1234, 32'hDEADBEEF, 5'd5,  32'h0,   5'd5,
                32'h55,   32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
    tbl[1]  = '{0, 2'd2, 32'h9,    5'd0,  32'h200, 0, 2'd0, 32'h77,   32'h0,  5'd0,  32'h0,   5'd5,
                32'h200,  32'h77, 32'hDEADBEEF, 32'd1};
    tbl[2]  = '{1, 2'd0, 32'h11,   5'd7,  32'h0,   1, 2'd0, 32'h22,   32'h0,  5'd7,  32'h0,   5'd7,
                32'h11,   32'h22, 32'h22, 32'd3};
    tbl[3]  = '{0, 2'd0, 32'h0,    5'd0,  32'h0,   0, 2'd0, 32'h0,    32'h0,  5'd0,  32'h0,   5'd7,
                32'h0,    32'h0,  32'h22, 32'd3};
    tbl[4]  = '{1, 2'd0, 32'hFFFF, 5'd0,  32'h0,   0, 2'd3, 32'h33,   32'h0,  5'd0,  32'h0,   5'd0,
                32'hFFFF, 32'h33, 32'h0,  32'd3};
    tbl[5]  = '{1, 2'd2, 32'hAA,   5'd1,  32'h104, 1, 2'd2, 32'h0,    32'h0,  5'd2,  32'h300, 5'd1,
                32'h104,  32'h300, 32'h104, 32'd5};
    tbl[6]  = '{0, 2'd1, 32'h9,    5'd0,  32'h0,   0, 2'd3, 32'h44,   32'h0,  5'd0,  32'h0,   5'd1,
                32'h9,    32'h44, 32'h104, 32'd5};
    tbl[7]  = '{1, 2'd0, 32'h99,   5'd9,  32'h0,   1, 2'd0, 32'h5,    32'h0,  5'd0,  32'h0,   5'd9,
                32'h99,   32'h5,  32'h99, 32'd6};
    tbl[8]  = '{1, 2'd0, 32'hA0,   5'd10, 32'h0,   1, 2'd1, 32'h0,    32'hB0, 5'd11, 32'h0,   5'd10,
                32'hA0,   32'hB0, 32'hA0, 32'd8};
    tbl[9]  = '{0, 2'd0, 32'h0,    5'd0,  32'h0,   0, 2'd0, 32'h0,    32'h0,  5'd0,  32'h0,   5'd11,
                32'h0,    32'h0,  32'hB0, 32'd8};
    tbl[10] = '{1, 2'd2, 32'h1,    5'd12, 32'h120, 1, 2'd1, 32'h2,    32'hC0, 5'd12, 32'h0,   5'd12,
                32'h120,  32'hC0, 32'hC0, 32'd10};
    tbl[11] = '{0, 2'd0, 32'h0,    5'd0,  32'h0,   0, 2'd0, 32'h0,    32'h0,  5'd0,  32'h0,   5'd12,
                32'h0,    32'h0,  32'hC0, 32'd10};

    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = '0;
    drive(idle, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    Rs1D = 5'd5;
    #1;
    check("reset.WrCount", 32'(WrCount), 32'h0);
    check("reset.RD1D", RD1D, 32'h0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i], 1'b1);
      #1;
      check($sformatf("vec%0d.ResultW_0", i), ResultW_0, tbl[i].e_res0);
      check($sformatf("vec%0d.ResultW", i),   ResultW,   tbl[i].e_res1);
      check($sformatf("vec%0d.RD1D", i),      RD1D,      tbl[i].e_rd1d);
      sample_model($sformatf("vec%0d", i));
      commit_edge($sformatf("vec%0d", i));
      check($sformatf("vec%0d.cnt", i), 32'(WrCount), tbl[i].e_cnt);
    end

    // Fill every register, then reset while lane 1 tries to write x3.
    for (int r = 1; r < 32; r++) begin
      w = idle; w.rw1 = 1'b1; w.rd1 = 5'(r); w.alu1 = 32'h1000_0000 | 32'(r); w.rs1 = 5'(r);
      step($sformatf("fill%0d", r), w, 1'b1);
    end
    w = idle; w.rw1 = 1'b1; w.rd1 = 5'd3; w.alu1 = 32'h3333; w.rs1 = 5'd3;
    drive(w, 1'b0);
    #1;
    check("rstwr.RD1D_no_bypass", RD1D, 32'h1000_0003);
    sample_model("rstwr");
    commit_edge("rstwr");
    check("rstwr.cnt", 32'(WrCount), 32'h0);
    for (int r = 1; r < 32; r++) begin
      w = idle; w.rs1 = 5'(r);
      drive(w, 1'b1);
      #1;
      check($sformatf("cleared.x%0d", r), RD1D, 32'h0);
      sample_model($sformatf("cleared%0d", r));
      commit_edge($sformatf("cleared%0d", r));
    end

    // Counter wrap: 15 single commits, then one dual commit wraps 15 -> 1.
    for (int k = 0; k < 15; k++) begin
      w = idle; w.rw0 = 1'b1; w.rd0 = 5'd1; w.alu0 = 32'(k); w.rs1 = 5'd1;
      step($sformatf("wrapfill%0d", k), w, 1'b1);
    end
    check("wrap.pre", 32'(WrCount), 32'd15);
    w = idle; w.rw0 = 1'b1; w.rd0 = 5'd2; w.alu0 = 32'hAB; w.rw1 = 1'b1; w.rd1 = 5'd3;
    w.alu1 = 32'hCD; w.rs1 = 5'd3;
    step("wrapdual", w, 1'b1);
    check("wrap.post", 32'(WrCount), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning architectural register count (x0..x31).
REQ-002 SHALL have parameter CNTW, default 32, meaning width of the write-commit counter.
REQ-003 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, synchronous, active-low (rst==0 resets on the next rising clk).
REQ-005 SHALL have ports for lane 0 writeback: RegWriteW_0 in 1, ResultSrcW_0 in 2, AluResultW_0 in 32, RdW_0 in 5, PCPlus4W_0 in 32.
REQ-006 SHALL have ports for lane 1 writeback: RegWriteW in 1, ResultSrcW in 2, AluResultW in 32, ReadDataW in 32, RdW in 5, PCPlus4W in 32.
REQ-007 SHALL have read ports: Rs1D_0, Rs2D_0, Rs1D, Rs2D in 5 each; RD1D_0, RD2D_0, RD1D, RD2D out 32 each.
REQ-008 SHALL have outputs ResultW_0 and ResultW out 32, meaning selected writeback data per lane, for forwarding.
REQ-009 SHALL have output WrCount out CNTW, meaning count of committed register writes since reset.

Function
REQ-010 SHALL compute ResultW (lane 1) combinationally: ResultSrcW 00 -> AluResultW, 01 -> ReadDataW, 10 -> PCPlus4W, 11 -> AluResultW.
REQ-011 SHALL compute ResultW_0 combinationally: 10 -> PCPlus4W_0; 00, 01, 11 -> AluResultW_0 (lane 0 has no memory path).
REQ-012 SHALL treat lane N write as committed when its RegWrite==1, its Rd!=0, and rst==1.
REQ-013 SHALL write committed results into register array at the rising clk; read-visible one cycle later via the array.
REQ-014 SHALL, when both lanes commit to the same Rd in one cycle, store lane 1 data only (lane 1 is program-younger).
REQ-015 SHALL never write x0; reads of address 0 SHALL return 32'h0 unconditionally.
REQ-016 SHALL provide combinational reads with write-through bypass: if read address equals a committing Rd this cycle, return that lane's Result, with lane 1 taking priority over lane 0.
REQ-017 SHALL otherwise return the stored array value for the read address.
REQ-018 SHALL have zero-cycle read latency and one-cycle write latency for the array; ResultW/ResultW_0 SHALL have zero latency.
REQ-019 SHALL increment WrCount each cycle by the number of committing lanes (0, 1, or 2), with same-Rd double commits counting 2.
REQ-020 SHALL let WrCount wrap modulo 2^CNTW with no saturation and no flag.
REQ-021 SHALL ignore RegWrite with Rd==0 for both storage and WrCount.

Reset
REQ-022 SHALL, on a rising clk with rst==0, clear all registers x1..x31 to 0 and WrCount to 0.
REQ-023 SHALL suppress commits, bypass and counting in any cycle with rst==0; reads then return array contents.
REQ-024 SHALL discard any write presented in the cycle rst deasserts only if rst was 0 at that edge; first commit occurs at the first edge with rst==1.
REQ-025 SHALL keep ResultW/ResultW_0 purely combinational and unaffected by rst.

Verification
REQ-026 Reset then lane 1 commit Rd=5, ResultSrc=01, ReadData=32'hDEADBEEF -> same cycle RD1D (Rs1D=5) returns DEADBEEF via bypass; next cycle from array; WrCount=1.
REQ-027 Both lanes commit Rd=7 (lane 0 Alu=32'h11, lane 1 Alu=32'h22) -> bypass and stored x7 = 32'h22; WrCount += 2.
REQ-028 Lane 0 RegWrite=1, Rd=0, Alu=32'hFFFF -> x0 reads 0, WrCount unchanged.
REQ-029 Lane 0 ResultSrc=10, PCPlus4=32'h104, Rd=1 -> x1=32'h104; lane 0 ResultSrc=01, Alu=32'h9 -> ResultW_0=32'h9.
REQ-030 Populate x1..x31, assert rst=0 for one clk while lane 1 commits Rd=3 -> all regs 0, x3 not written, WrCount=0.
REQ-031 Preload WrCount near wrap (CNTW=4, 15 commits) then dual commit -> WrCount=1.
